// File: rtl/dpsram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : dpsram_stream_reader
// Brief    : Drains a START_ADDR/LENGTH window from the dual-port sample RAM
//            (port B) onto a valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module dpsram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] START_ADDR,
    input  logic [ADDR_WIDTH:0]   LENGTH,
    input  logic                  ABORT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  M_LAST
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH:0]   rem_iss_q, rem_iss_d;
    logic [ADDR_WIDTH:0]   rem_del_q, rem_del_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_cnt_pop;
    logic [ADDR_WIDTH:0]   w_len;

    assign w_pop     = (cnt_q != 2'd0) && M_READY;
    assign w_cnt_pop = cnt_q - {1'b0, w_pop};
    assign w_len     = (LENGTH > c_DEPTH) ? c_DEPTH : LENGTH;

    // Buffer slots already owed (held words plus the read in flight) must
    // leave room for the new word after this cycle's pop.
    assign w_issue = (state_q == S_RUN) && !ABORT && (rem_iss_q != '0) &&
                     ((cnt_q + {1'b0, inflight_q}) < (2'd2 + {1'b0, w_pop}));

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        ram_addr_d = ram_addr_q;
        rem_iss_d  = rem_iss_q;
        rem_del_d  = rem_del_q;
        inflight_d = inflight_q;
        cnt_d      = cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (w_len != '0) begin
                        state_d   = S_RUN;
                        busy_d    = 1'b1;
                        addr_d    = START_ADDR;
                        rem_iss_d = w_len;
                        rem_del_d = w_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cnt_d      = 2'd0;
                    inflight_d = 1'b0;
                    rem_iss_d  = '0;
                    rem_del_d  = '0;
                end else begin
                    if (w_issue) begin
                        ram_addr_d = addr_q;
                        addr_d     = addr_q + 1'b1;
                        rem_iss_d  = rem_iss_q - 1'b1;
                    end
                    inflight_d = w_issue;
                    if (w_pop) begin
                        buf0_d = buf1_q;
                    end
                    // Returning read lands in the first slot free after the pop.
                    if (inflight_q) begin
                        if (w_cnt_pop == 2'd0) begin
                            buf0_d = RAM_DOUT;
                        end else begin
                            buf1_d = RAM_DOUT;
                        end
                    end
                    cnt_d = w_cnt_pop + {1'b0, inflight_q};
                    if (w_pop) begin
                        rem_del_d = rem_del_q - 1'b1;
                        if (rem_del_q == c_ONE) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            ram_addr_q <= '0;
            rem_iss_q  <= '0;
            rem_del_q  <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr_d;
            rem_iss_q  <= rem_iss_d;
            rem_del_q  <= rem_del_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RAM_ADDR = w_issue ? addr_q : ram_addr_q;
    assign M_DATA   = buf0_q;
    assign M_VALID  = (cnt_q != 2'd0);
    assign M_LAST   = (cnt_q != 2'd0) && (rem_del_q == c_ONE);

endmodule
`default_nettype wire

// File: tb/tb_dpsram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpsram_stream_reader
// Brief    : Directed bench for dpsram_stream_reader against a word[i]=i RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpsram_stream_reader;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [9:0]  START_ADDR;
    logic [10:0] LENGTH;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  RAM_ADDR;
    logic [63:0] RAM_DOUT;
    logic [63:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic        M_LAST;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [1024];
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [63:0] q_data [$];
    bit          q_last [$];
    int          q_j    [$];
    int          done_j;
    int          first_valid_j;
    bit          busy_seen;
    bit          valid_seen;
    bit          timed_out;
    int          stall_bad;

    dpsram_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .START_ADDR(START_ADDR),
        .LENGTH(LENGTH), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
        .RAM_ADDR(RAM_ADDR), .RAM_DOUT(RAM_DOUT), .M_DATA(M_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'(i);
    end
    always @(posedge CLK) RAM_DOUT <= mem[RAM_ADDR];

    // Pulse START (optionally with ABORT) for one cycle; returns just after the latch edge.
    task automatic start_xfer(input int addr, input int len, input bit with_abort);
        START      = 1'b1;
        START_ADDR = 10'(addr);
        LENGTH     = 11'(len);
        ABORT      = with_abort;
        @(posedge CLK); #1;
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    // Collect beats until DONE; j counts edges since the START latch edge.
    task automatic drain(input int j0, input bit toggle, input int budget);
        bit          prev_stall;
        logic [63:0] prev_data;
        bit          prev_last;
        bit          got_done;
        q_data.delete(); q_last.delete(); q_j.delete();
        done_j = -1; first_valid_j = -1; busy_seen = 0; valid_seen = 0;
        stall_bad = 0; prev_stall = 0; prev_data = '0; prev_last = 0; got_done = 0;
        for (int j = j0; j < j0 + budget && !got_done; j++) begin
            M_READY = toggle ? pat[j % 6] : 1'b1;
            @(negedge CLK);
            if (prev_stall && (!M_VALID || M_DATA !== prev_data || M_LAST !== prev_last))
                stall_bad++;
            prev_stall = M_VALID && !M_READY;
            prev_data  = M_DATA;
            prev_last  = M_LAST;
            if (M_VALID) begin
                valid_seen = 1;
                if (first_valid_j < 0) first_valid_j = j;
            end
            if (BUSY) busy_seen = 1;
            if (M_VALID && M_READY) begin
                q_data.push_back(M_DATA); q_last.push_back(M_LAST); q_j.push_back(j);
            end
            if (DONE) begin
                done_j = j; got_done = 1;
            end
            @(posedge CLK); #1;
            START = 1'b0;
        end
        timed_out = !got_done;
        M_READY = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 0; ABORT = 0; START_ADDR = '0; LENGTH = '0; M_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
        checks++; if (RAM_ADDR !== 10'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d want 0", RAM_ADDR); end
        checks++; if (M_VALID !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", M_VALID); end
        checks++; if (M_LAST !== 1'b0)   begin errors++; $display("FAIL reset_last: got %b want 0", M_LAST); end
        checks++; if (M_DATA !== 64'd0)  begin errors++; $display("FAIL reset_data: got %0d want 0", M_DATA); end
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        logic [63:0] got;
        start_xfer(5, 4, 0);
        drain(0, 0, 40);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: no DONE within 40 cycles"); end
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", q_data.size()); end
        checks++; if (first_valid_j != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", first_valid_j); end
        for (int i = 0; i < 4; i++) begin
            got = (i < q_data.size()) ? q_data[i] : 64'hFFFF;
            checks++; if (got !== 64'(5 + i)) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, got, 5 + i); end
            checks++; if (i < q_j.size() && q_j[i] != 2 + i) begin errors++; $display("FAIL basic_beat_cycle[%0d]: got %0d want %0d", i, q_j[i], 2 + i); end
            checks++; if (i < q_last.size() && q_last[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", i, q_last[i], i == 3); end
        end
        checks++; if (done_j != 6) begin errors++; $display("FAIL basic_done_cycle: got %0d want 6", done_j); end
        checks++; if (!busy_seen) begin errors++; $display("FAIL basic_busy: got 0 want 1"); end
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL basic_after_done: got done=%b busy=%b want 0/0", DONE, BUSY); end
    endtask

    task automatic test_wrap();
        int          exp_a [4] = '{1022, 1023, 0, 1};
        logic [63:0] got;
        start_xfer(1022, 4, 0);
        drain(0, 0, 40);
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < q_data.size()) ? q_data[i] : 64'hFFFF;
            checks++; if (got !== 64'(exp_a[i])) begin errors++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, got, exp_a[i]); end
        end
        checks++; if (q_last.size() == 4 && (q_last[3] !== 1'b1 || q_last[2] !== 1'b0)) begin errors++; $display("FAIL wrap_last: got %b%b want 01", q_last[2], q_last[3]); end
    endtask

    task automatic test_backpressure();
        logic [63:0] got;
        int          nlast = 0;
        start_xfer(0, 6, 0);
        drain(0, 1, 80);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: no DONE within 80 cycles"); end
        checks++; if (q_data.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", q_data.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < q_data.size()) ? q_data[i] : 64'hFFFF;
            checks++; if (got !== 64'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got, i); end
        end
        foreach (q_last[i]) if (q_last[i]) nlast++;
        checks++; if (nlast != 1 || q_last.size() != 6 || !q_last[5]) begin errors++; $display("FAIL bp_last: got %0d last flags want 1 on beat 5", nlast); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_bad); end
    endtask

    task automatic test_zero_length();
        start_xfer(77, 0, 0);
        drain(0, 0, 6);
        checks++; if (done_j != 0) begin errors++; $display("FAIL zero_done_cycle: got %0d want 0", done_j); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy: got 1 want 0"); end
        checks++; if (valid_seen) begin errors++; $display("FAIL zero_valid: got 1 want 0"); end
        checks++; if (RAM_ADDR !== 10'd5) begin errors++; $display("FAIL zero_ram_addr_hold: got %0d want 5", RAM_ADDR); end
    endtask

    task automatic test_window(input string name, input int addr, input int len, input int exp_n);
        int bad = 0;
        int nlast = 0;
        start_xfer(addr, len, 0);
        drain(0, 0, exp_n + 40);
        checks++; if (q_data.size() != exp_n) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, q_data.size(), exp_n); end
        foreach (q_data[i]) if (q_data[i] !== 64'((addr + i) % 1024)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_data: got %0d wrong beats want 0", name, bad); end
        foreach (q_last[i]) if (q_last[i]) nlast++;
        checks++; if (nlast != 1 || q_last.size() != exp_n || !q_last[exp_n - 1]) begin errors++; $display("FAIL %s_last: got %0d last flags want 1 on final beat", name, nlast); end
    endtask

    task automatic test_abort();
        int nb = 0;
        bit aborted = 0;
        start_xfer(20, 8, 0);
        for (int j = 0; j < 20 && !aborted; j++) begin
            if (M_VALID && nb == 2) begin
                checks++; if (M_DATA !== 64'd22) begin errors++; $display("FAIL abort_third_beat: got %0d want 22", M_DATA); end
                ABORT = 1'b1; M_READY = 1'b0;
                @(posedge CLK); #1;
                ABORT = 1'b0; M_READY = 1'b1;
                checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", M_VALID); end
                checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", DONE); end
                checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", BUSY); end
                @(posedge CLK); #1;
                checks++; if (DONE !== 1'b0 || M_VALID !== 1'b0) begin errors++; $display("FAIL abort_settle: got done=%b valid=%b want 0/0", DONE, M_VALID); end
                aborted = 1;
            end else begin
                M_READY = 1'b1;
                @(negedge CLK);
                if (M_VALID && M_READY) nb++;
                @(posedge CLK); #1;
            end
        end
        checks++; if (!aborted) begin errors++; $display("FAIL abort_reached: got %0d beats want third beat within 20 cycles", nb); end
        test_window("restart", 100, 2, 2);
    endtask

    task automatic test_start_while_busy();
        logic [63:0] got;
        start_xfer(200, 5, 0);
        START = 1'b1; START_ADDR = 10'd600; LENGTH = 11'd3;
        drain(0, 0, 40);
        checks++; if (q_data.size() != 5) begin errors++; $display("FAIL busy_start_count: got %0d want 5", q_data.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < q_data.size()) ? q_data[i] : 64'hFFFF;
            checks++; if (got !== 64'(200 + i)) begin errors++; $display("FAIL busy_start_data[%0d]: got %0d want %0d", i, got, 200 + i); end
        end
        checks++; if (done_j != 7) begin errors++; $display("FAIL busy_start_done_cycle: got %0d want 7", done_j); end
    endtask

    task automatic test_idle_abort();
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL idle_abort: got done=%b busy=%b want 0/0", DONE, BUSY); end
        start_xfer(300, 2, 1);
        drain(0, 0, 30);
        checks++; if (q_data.size() != 2 || q_data[0] !== 64'd300 || q_data[1] !== 64'd301) begin
            errors++; $display("FAIL start_abort_idle: got %0d beats want 2 beats 300,301", q_data.size());
        end
    endtask

    task automatic test_reset_mid();
        start_xfer(0, 50, 0);
        repeat (4) begin @(posedge CLK); #1; end
        checks++; if (M_VALID !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got valid=%b busy=%b want 1/1", M_VALID, BUSY); end
        RST_N = 1'b0;
        #1;
        checks++; if (BUSY !== 0 || DONE !== 0 || M_VALID !== 0 || M_LAST !== 0 || RAM_ADDR !== 0 || M_DATA !== 0) begin
            errors++; $display("FAIL rst_mid: got busy=%b done=%b valid=%b last=%b addr=%0d data=%0d want all 0",
                               BUSY, DONE, M_VALID, M_LAST, RAM_ADDR, M_DATA);
        end
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_window("full", 0, 1024, 1024);
        test_window("clamp", 512, 2047, 1024);
        test_abort();
        test_start_while_busy();
        test_idle_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
